// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller.
// Optional statistics counters are enabled with the BRC_STATS_EN macro.
// In-flight entries store PCs at BRC_PC_W bits, so ADDR_W may be at most BRC_PC_W.
package branch_resolve_ctrl_pkg;

    localparam int unsigned BRC_PC_W = 32;
    localparam int unsigned PC_INCR  = 4;

    typedef struct packed {
        logic [BRC_PC_W-1:0] pc;
        logic                pred_taken;
        logic [BRC_PC_W-1:0] pred_target;
    } brc_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } brc_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Fetch / resolve / predictor-update bundle for branch_resolve_ctrl.
// The statistics outputs exist only when BRC_STATS_EN is defined.
interface branch_resolve_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);

    logic                    fetch_valid;
    logic [ADDR_W-1:0]       fetch_pc;
    logic                    fetch_pred_taken;
    logic [ADDR_W-1:0]       fetch_pred_target;
    logic                    fetch_stall;
    logic                    res_valid;
    logic                    res_taken;
    logic [ADDR_W-1:0]       res_target;
    logic                    upd_valid;
    logic                    upd_taken;
    logic                    mispredict;
    logic [ADDR_W-1:0]       redirect_pc;
    logic [$clog2(DEPTH):0]  occupancy;
`ifdef BRC_STATS_EN
    logic [31:0]             pred_count;
    logic [31:0]             mispred_count;
`endif

    // Driver side: fetch and branch-confirm stages.
    modport master (
        output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        output res_valid, res_taken, res_target,
        input  fetch_stall, upd_valid, upd_taken, mispredict, redirect_pc, occupancy
`ifdef BRC_STATS_EN
        , input pred_count, mispred_count
`endif
    );

    // Controller side.
    modport slave (
        input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
        input  res_valid, res_taken, res_target,
        output fetch_stall, upd_valid, upd_taken, mispredict, redirect_pc, occupancy
`ifdef BRC_STATS_EN
        , output pred_count, mispred_count
`endif
    );

endinterface

// File: rtl/branch_resolve_ctrl_inflight_fifo.sv
// In-order circular buffer of in-flight predicted branches.
// Clear has priority over push/pop; occupancy disambiguates full from empty.
module branch_inflight_fifo
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    push,
    input  brc_entry_t              push_data,
    input  logic                    pop,
    output brc_entry_t              head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    brc_entry_t        mem_q [DEPTH];
    brc_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and count; clear wipes the pointers.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Register the buffer state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: tracks predicted branches in order, compares the
// prediction with the resolved outcome, schedules predictor updates and raises
// a registered redirect plus fetch hold on a mispredict.
// Optional feature macro: BRC_STATS_EN (pred_count / mispred_count outputs).
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_resolve_ctrl_if.slave    bus
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    brc_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           flush_cnt_q, flush_cnt_d;
    logic                       upd_valid_q, upd_valid_d;
    logic                       upd_taken_q, upd_taken_d;
    logic                       mispredict_q, mispredict_d;
    logic [ADDR_W-1:0]          redirect_pc_q, redirect_pc_d;

    brc_entry_t                 push_entry;
    brc_entry_t                 head_entry;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_clear;
    logic [$clog2(DEPTH):0]     fifo_count;

    logic                       pop_accept;
    logic                       mis_now;
    logic [ADDR_W-1:0]          head_pc;
    logic [ADDR_W-1:0]          head_target;
    logic [ADDR_W-1:0]          correct_pc;
    logic                       head_unused;

    branch_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Stall is decoded purely from registered state.
    assign bus.fetch_stall = fifo_full || (state_q == FLUSH);
    assign bus.occupancy   = fifo_count;
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.redirect_pc = redirect_pc_q;

    // Direction is implied by the stored target, so pred_taken is only kept for visibility.
    assign head_unused = head_entry.pred_taken;

    // Push/pop qualification and the correct-next-PC comparison.
    always_comb begin
        push_entry             = '0;
        push_entry.pc          = BRC_PC_W'(bus.fetch_pc);
        push_entry.pred_taken  = bus.fetch_pred_taken;
        push_entry.pred_target = BRC_PC_W'(bus.fetch_pred_target);
        head_pc                = ADDR_W'(head_entry.pc);
        head_target            = ADDR_W'(head_entry.pred_target);
        pop_accept             = bus.res_valid && (state_q == RUN) && !fifo_empty;
        correct_pc             = bus.res_taken ? bus.res_target : (head_pc + ADDR_W'(PC_INCR));
        mis_now                = pop_accept && (correct_pc != head_target);
        fifo_push              = bus.fetch_valid && !bus.fetch_stall;
        fifo_pop               = pop_accept;
        fifo_clear             = mis_now;
    end

    // FSM next state, flush counter and registered resolve outputs.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        upd_valid_d   = pop_accept;
        upd_taken_d   = pop_accept && bus.res_taken;
        mispredict_d  = mis_now;
        redirect_pc_d = redirect_pc_q;
        if (mis_now) begin
            redirect_pc_d = correct_pc;
        end
        case (state_q)
            RUN: begin
                if (mis_now) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            flush_cnt_q   <= '0;
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            upd_valid_q   <= upd_valid_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

`ifdef BRC_STATS_EN
    logic [31:0] pred_cnt_q, pred_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    assign bus.pred_count    = pred_cnt_q;
    assign bus.mispred_count = mispred_cnt_q;

    // Saturating counts of accepted resolves and mispredicts.
    always_comb begin
        pred_cnt_d    = pred_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (pop_accept && (pred_cnt_q != 32'hFFFF_FFFF)) begin
            pred_cnt_d = pred_cnt_q + 32'd1;
        end
        if (mis_now && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pred_cnt_q    <= pred_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl.
// Expected predictor updates are queued when a resolve is driven and
// compared when the DUT presents them one cycle later.
module tb_branch_resolve_ctrl;

    localparam int DEPTH        = 4;
    localparam int ADDR_W       = 32;
    localparam int FLUSH_CYCLES = 2;

    typedef struct {
        logic              taken;
        logic              mis;
        logic [ADDR_W-1:0] redirect;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t exp_q[$];
    ent_t model_q[$];
    int   flush_left = 0;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_ctrl_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    branch_resolve_ctrl #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // After each edge: pop the scoreboard if an update is due and check occupancy.
    task automatic monitorCycle();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("upd_valid", bus.upd_valid, 1);
            checkOutput("upd_taken", bus.upd_taken, e.taken);
            checkOutput("mispredict", bus.mispredict, e.mis);
            if (e.mis) checkOutput("redirect_pc", bus.redirect_pc, e.redirect);
        end else begin
            checkOutput("upd_valid_idle", bus.upd_valid, 0);
            checkOutput("mispredict_idle", bus.mispredict, 0);
        end
        checkOutput("occupancy", bus.occupancy, model_q.size());
    endtask

    // Drive one cycle of fetch/resolve stimulus and predict the outcome.
    task automatic applyStimulus(input logic fv, input logic [ADDR_W-1:0] pc, input logic pt,
                                 input logic [ADDR_W-1:0] tgt, input logic rv, input logic rt,
                                 input logic [ADDR_W-1:0] rtgt);
        logic              stall_exp;
        logic              mis;
        logic [ADDR_W-1:0] correct;
        ent_t              e;
        exp_t              x;
        bus.fetch_valid       = fv;
        bus.fetch_pc          = pc;
        bus.fetch_pred_taken  = pt;
        bus.fetch_pred_target = tgt;
        bus.res_valid         = rv;
        bus.res_taken         = rt;
        bus.res_target        = rtgt;
        stall_exp = (model_q.size() == DEPTH) || (flush_left > 0);
        checkOutput("fetch_stall", bus.fetch_stall, stall_exp);
        mis = 1'b0;
        if (rv && (flush_left == 0) && (model_q.size() > 0)) begin
            e         = model_q.pop_front();
            correct   = rt ? rtgt : e.pc + ADDR_W'(4);
            mis       = (correct != e.target);
            x.taken   = rt;
            x.mis     = mis;
            x.redirect = correct;
            exp_q.push_back(x);
        end
        if (mis) begin
            model_q.delete();
        end else if (fv && !stall_exp) begin
            e.pc     = pc;
            e.target = tgt;
            model_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (mis) flush_left = FLUSH_CYCLES;
        else if (flush_left > 0) flush_left--;
        monitorCycle();
    endtask

    task automatic fetchOnly(input logic [ADDR_W-1:0] pc, input logic pt, input logic [ADDR_W-1:0] tgt);
        applyStimulus(1'b1, pc, pt, tgt, 1'b0, 1'b0, '0);
    endtask

    task automatic resolveOnly(input logic rt, input logic [ADDR_W-1:0] rtgt);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, rt, rtgt);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Synchronous reset for one edge, then check every reset value.
    task automatic resetDut();
        rst                   = 1'b1;
        bus.fetch_valid       = 1'b0;
        bus.fetch_pc          = '0;
        bus.fetch_pred_taken  = 1'b0;
        bus.fetch_pred_target = '0;
        bus.res_valid         = 1'b0;
        bus.res_taken         = 1'b0;
        bus.res_target        = '0;
        @(posedge clk);
        #1;
        model_q.delete();
        exp_q.delete();
        flush_left = 0;
        checkOutput("rst_fetch_stall", bus.fetch_stall, 0);
        checkOutput("rst_upd_valid", bus.upd_valid, 0);
        checkOutput("rst_upd_taken", bus.upd_taken, 0);
        checkOutput("rst_mispredict", bus.mispredict, 0);
        checkOutput("rst_redirect_pc", bus.redirect_pc, 0);
        checkOutput("rst_occupancy", bus.occupancy, 0);
`ifdef BRC_STATS_EN
        checkOutput("rst_pred_count", bus.pred_count, 0);
        checkOutput("rst_mispred_count", bus.mispred_count, 0);
`endif
        rst = 1'b0;
    endtask

    // Directed scenario sequence.
    initial begin
        resetDut();

        $display("[TB] correctly predicted not-taken branch");
        fetchOnly(32'h100, 1'b0, 32'h104);
        resolveOnly(1'b0, 32'h0);

        $display("[TB] direction mispredict with flush window");
        fetchOnly(32'h200, 1'b0, 32'h204);
        resolveOnly(1'b1, 32'h300);
        resolveOnly(1'b0, 32'h0);
        idleCycle();
        resolveOnly(1'b1, 32'h340);

        $display("[TB] full queue, dropped fetch, pop with push attempt");
        fetchOnly(32'h10, 1'b0, 32'h14);
        fetchOnly(32'h20, 1'b0, 32'h24);
        fetchOnly(32'h30, 1'b0, 32'h34);
        fetchOnly(32'h40, 1'b0, 32'h44);
        fetchOnly(32'h50, 1'b0, 32'h54);
        applyStimulus(1'b1, 32'h60, 1'b0, 32'h64, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h70, 1'b0, 32'h74, 1'b1, 1'b0, 32'h0);
        resolveOnly(1'b0, 32'h0);
        resolveOnly(1'b0, 32'h0);
        resolveOnly(1'b0, 32'h0);

        $display("[TB] fall-through PC wraps around the address space");
        fetchOnly(32'hFFFF_FFFC, 1'b0, 32'h0);
        resolveOnly(1'b0, 32'h0);

        $display("[TB] taken target mispredict");
        fetchOnly(32'h500, 1'b1, 32'h400);
        resolveOnly(1'b1, 32'h480);
        idleCycle();
        idleCycle();

        $display("[TB] predicted taken, actually not taken, wrong-path entry discarded");
        fetchOnly(32'h600, 1'b1, 32'h700);
        fetchOnly(32'h700, 1'b0, 32'h704);
        applyStimulus(1'b1, 32'h800, 1'b0, 32'h804, 1'b1, 1'b0, 32'h0);
        idleCycle();
        idleCycle();

        $display("[TB] statistics and mid-run reset");
        resetDut();
        fetchOnly(32'h100, 1'b0, 32'h104);
        fetchOnly(32'h108, 1'b0, 32'h10C);
        resolveOnly(1'b0, 32'h0);
        resolveOnly(1'b0, 32'h0);
        fetchOnly(32'h120, 1'b0, 32'h124);
        resolveOnly(1'b1, 32'h200);
`ifdef BRC_STATS_EN
        checkOutput("pred_count", bus.pred_count, 3);
        checkOutput("mispred_count", bus.mispred_count, 1);
`endif
        idleCycle();
        idleCycle();
        fetchOnly(32'h900, 1'b0, 32'h904);
        fetchOnly(32'h910, 1'b0, 32'h914);
        resetDut();
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequences the branch predictor between fetch and the branch-confirmed stage. It records each predicted conditional branch in an in-order in-flight queue. At resolution it compares the prediction with the outcome and schedules the predictor state update. On a misprediction it raises a registered redirect/flush and holds fetch for a fixed recovery window.

## Interface
Parameters:
- DEPTH, 4: in-flight branch entries; power of two, ≥2
- ADDR_W, 32: PC width
- FLUSH_CYCLES, 2: fetch-hold cycles after a mispredict; ≥1

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset (rst == RESET, RESET = 1'b1)
- fetch_valid  in  1  fetch issues a conditional branch this cycle
- fetch_pc  in  ADDR_W  branch PC
- fetch_pred_taken  in  1  predictor output for this branch
- fetch_pred_target  in  ADDR_W  PC fetch followed after the branch
- fetch_stall  out  1  fetch must not issue branches this cycle
- res_valid  in  1  oldest in-flight branch resolves this cycle
- res_taken  in  1  actual direction
- res_target  in  ADDR_W  actual taken target
- upd_valid  out  1  predictor update strobe (drives predictor isBranch)
- upd_taken  out  1  predictor update direction (drives isBranchTaken)
- mispredict  out  1  one-cycle flush pulse
- redirect_pc  out  ADDR_W  correct next PC, valid with mispredict
- occupancy  out  $clog2(DEPTH)+1  current entry count
- pred_count, mispred_count  out  32 each  statistics, present only with BRC_STATS_EN

## Operation
- FSM states: RUN, FLUSH. Reset enters RUN.
- Push: fetch_valid && !fetch_stall writes {fetch_pc, fetch_pred_taken, fetch_pred_target} at the tail.
- Pop: res_valid in RUN with occupancy>0 reads the head entry.
- res_valid while the queue is empty is ignored: no update and no mispredict.
- Correct next PC = res_taken ? res_target : fetch_pc+4, computed modulo 2^ADDR_W.
- Mispredict condition = correct next PC != entry pred_target. This covers both wrong direction and wrong target.
- Every accepted pop produces upd_valid=1 and upd_taken=res_taken on the next cycle, whether or not it mispredicted.
- On a mispredict:
  - mispredict=1 and redirect_pc=correct PC on the next cycle.
  - The queue is cleared on the same edge, discarding all wrong-path entries.
  - Any same-cycle push is dropped.
  - FSM moves to FLUSH.
- FLUSH:
  - fetch_stall=1.
  - res_valid is ignored (wrong path).
  - An internal counter runs for FLUSH_CYCLES cycles, then the FSM returns to RUN.
- Simultaneous push and pop in RUN without mispredict: both occur; occupancy unchanged.
- Reset mid-operation clears the queue, the FSM state and all outputs on that edge.

## Timing
- Reset values:
  - fetch_stall=0, upd_valid=0, upd_taken=0, mispredict=0
  - redirect_pc=0, occupancy=0
  - statistics counters=0
- fetch_stall = (occupancy==DEPTH) || state==FLUSH. It is decoded from registers only, with no combinational path from inputs.
- A full queue stalls fetch even in a cycle where a pop occurs; fetch may issue again the following cycle.
- upd_valid, upd_taken, mispredict and redirect_pc are registered: 1-cycle latency from res_valid.
- fetch_stall rises the cycle mispredict is high and stays high for FLUSH_CYCLES cycles.
- Queue pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy disambiguates full from empty.

## Configuration
- BRC_STATS_EN defined:
  - pred_count increments on each accepted pop.
  - mispred_count increments on each mispredict.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: the stat ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - brc_entry_t struct: pc, pred_taken, pred_target
  - brc_state_t enum: RUN, FLUSH
  - PC_INCR constant (4)
- Sub-module branch_inflight_fifo: circular buffer with push, pop and a synchronous clear, exposing head entry, full, empty and count.
- Compare/FSM logic stays in branch_resolve_ctrl.

## Test plan
- Reset, then fetch_valid with pc=0x100, pred_taken=0, target=0x104; res_valid, res_taken=0 -> next cycle upd_valid=1, upd_taken=0, mispredict=0, occupancy returns to 0.
- Push pc=0x200, pred_taken=0, target=0x204; resolve res_taken=1, res_target=0x300 -> mispredict=1, redirect_pc=0x300, fetch_stall high 2 cycles, occupancy=0.
- Push 4 branches with no resolves -> fetch_stall=1 with occupancy=4. A 5th fetch_valid is not queued. One pop with a same-cycle push attempt -> occupancy=3; stall clears next cycle.
- Predicted taken to 0x400, actual taken to 0x480 -> mispredict=1, redirect_pc=0x480, upd_taken=1.
- res_valid during FLUSH, and res_valid with an empty queue -> no upd_valid, no mispredict.
- With BRC_STATS_EN: 3 resolves including 1 mispredict -> pred_count=3, mispred_count=1. Assert rst mid-run -> both counters 0 and occupancy=0 next cycle.
